// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: state encoding and counter sizing helpers shared by the PLL reset sequencer.
package pll_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 3'd0,
        ST_ASSERT_RST = 3'd1,
        ST_WAIT_LOCK  = 3'd2,
        ST_RELEASE    = 3'd3,
        ST_RUN        = 3'd4,
        ST_FAIL       = 3'd5
    } state_e;

    function automatic int cnt_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: two-flop synchroniser for the asynchronous PLL lock indications.
module pll_lock_sync #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: drives PLL resets, waits for debounced lock with timeout/retry,
// then releases downstream domain resets in ascending order; re-sequences on lock loss.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_PLL             = 2,
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1000,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int MAX_RETRIES         = 3,
    parameter int RELEASE_GAP         = 4,
    parameter int CNT_W               = 8
) (
    input  logic                               refclk,
    input  logic                               rst,
    input  logic [NUM_PLL-1:0]                 enable_i,
    input  logic                               restart_i,
    input  logic [NUM_PLL-1:0]                 pll_locked_i,
    output logic [NUM_PLL-1:0]                 pll_rst_o,
    output logic [NUM_PLL-1:0]                 domain_rst_o,
    output logic                               all_locked_o,
    output logic                               fail_o,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count_o,
    output logic [CNT_W-1:0]                   lock_loss_count_o,
    output logic [STATE_W-1:0]                 state_o
);

    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int TMR_W   = cnt_w(max_i(max_i(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES), RELEASE_GAP));
    localparam int STB_W   = cnt_w(LOCK_STABLE_CYCLES);

    state_e               state_q, state_d;
    logic [NUM_PLL-1:0]   lk;
    logic [NUM_PLL-1:0]   en_q, en_d;
    logic [NUM_PLL-1:0]   prst_q, prst_d;
    logic [NUM_PLL-1:0]   drst_q, drst_d;
    logic [NUM_PLL-1:0]   pend, next_bit, first_bit;
    logic [TMR_W-1:0]     tmr_q, tmr_d, tmr_inc;
    logic [STB_W-1:0]     stb_q, stb_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [CNT_W-1:0]     loss_q, loss_d;
    logic                 all_q, fail_q;
    logic                 ok, lost;

    pll_lock_sync #(.W(NUM_PLL)) u_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked_i),
        .q_o   (lk)
    );

    assign ok        = (lk & en_q) == en_q;
    assign lost      = (state_q == ST_RUN || state_q == ST_RELEASE) && !ok;
    assign tmr_inc   = tmr_q + TMR_W'(1);
    assign pend      = en_q & drst_q;
    assign next_bit  = pend & (~pend + NUM_PLL'(1));
    assign first_bit = en_q & (~en_q + NUM_PLL'(1));

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        tmr_d   = tmr_inc;
        stb_d   = '0;
        retry_d = retry_q;
        drst_d  = drst_q;
        loss_d  = (lost && loss_q != '1) ? loss_q + CNT_W'(1) : loss_q;
        if (restart_i && state_q != ST_IDLE) begin
            state_d = ST_ASSERT_RST;
            en_d    = enable_i;
            tmr_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (enable_i != '0) begin
                    state_d = ST_ASSERT_RST;
                    en_d    = enable_i;
                    tmr_d   = '0;
                end
                ST_ASSERT_RST: if (tmr_inc == TMR_W'(RST_PULSE_CYCLES)) begin
                    state_d = ST_WAIT_LOCK;
                    tmr_d   = '0;
                end
                ST_WAIT_LOCK: begin
                    stb_d = ok ? stb_q + STB_W'(1) : '0;
                    // stable lock takes priority over a timeout landing in the same cycle
                    if (stb_d == STB_W'(LOCK_STABLE_CYCLES)) begin
                        state_d = ST_RELEASE;
                        tmr_d   = '0;
                        retry_d = '0;
                        drst_d  = ~first_bit;
                    end else if (tmr_inc == TMR_W'(LOCK_TIMEOUT_CYCLES)) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = (retry_d == RETRY_W'(MAX_RETRIES)) ? ST_FAIL : ST_ASSERT_RST;
                        tmr_d   = '0;
                    end
                end
                ST_RELEASE: if (lost) begin
                    state_d = ST_ASSERT_RST;
                    tmr_d   = '0;
                    retry_d = '0;
                end else if (pend == '0) begin
                    state_d = ST_RUN;
                end else if (tmr_inc == TMR_W'(RELEASE_GAP)) begin
                    drst_d = drst_q & ~next_bit;
                    tmr_d  = '0;
                end
                ST_RUN: if (lost) begin
                    state_d = ST_ASSERT_RST;
                    tmr_d   = '0;
                    retry_d = '0;
                end
                default: ;
            endcase
        end
        prst_d = (state_d inside {ST_WAIT_LOCK, ST_RELEASE, ST_RUN}) ? ~en_d : '1;
        if (!(state_d inside {ST_RELEASE, ST_RUN})) drst_d = '1;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            en_q    <= '0;
            tmr_q   <= '0;
            stb_q   <= '0;
            retry_q <= '0;
            loss_q  <= '0;
            prst_q  <= '1;
            drst_q  <= '1;
            all_q   <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            tmr_q   <= tmr_d;
            stb_q   <= stb_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
            prst_q  <= prst_d;
            drst_q  <= drst_d;
            all_q   <= state_d == ST_RUN;
            fail_q  <= state_d == ST_FAIL;
        end
    end

    assign pll_rst_o         = prst_q;
    assign domain_rst_o      = drst_q;
    assign all_locked_o      = all_q;
    assign fail_o            = fail_q;
    assign retry_count_o     = retry_q;
    assign lock_loss_count_o = loss_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: emulated PLLs plus a cycle-level behavioural model of the
// sequencing rules; every output is compared each cycle, with directed boundary checks.
module tb_pll_reset_sequencer;

    localparam int NP = 2, RP = 4, LS = 8, TO = 32, MR = 3, RG = 2, CW = 2;
    localparam int S_IDLE = 0, S_AST = 1, S_WAIT = 2, S_REL = 3, S_RUN = 4, S_FAIL = 5;

    logic          refclk = 1'b0;
    logic          rst, restart_i;
    logic [NP-1:0] enable_i, pll_locked_i, pll_rst_o, domain_rst_o;
    logic          all_locked_o, fail_o;
    logic [1:0]    retry_count_o;
    logic [CW-1:0] lock_loss_count_o;
    logic [2:0]    state_o;

    int n_vec = 0, n_err = 0;

    int            m_st, m_el, m_run, m_gap, m_retry, m_loss;
    logic [NP-1:0] m_en, m_prst, m_drst, h1, h2;
    int            relq[$];

    int            pcnt[NP], dly[NP];
    bit            dead[NP];
    logic [NP-1:0] glitch;
    bit            rand_mode;

    pll_reset_sequencer #(
        .NUM_PLL(NP), .RST_PULSE_CYCLES(RP), .LOCK_STABLE_CYCLES(LS),
        .LOCK_TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR), .RELEASE_GAP(RG), .CNT_W(CW)
    ) dut (
        .refclk(refclk), .rst(rst), .enable_i(enable_i), .restart_i(restart_i),
        .pll_locked_i(pll_locked_i), .pll_rst_o(pll_rst_o), .domain_rst_o(domain_rst_o),
        .all_locked_o(all_locked_o), .fail_o(fail_o), .retry_count_o(retry_count_o),
        .lock_loss_count_o(lock_loss_count_o), .state_o(state_o)
    );

    always #50 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic to_assert();
        m_st  = S_AST;
        m_el  = 0;
        m_run = 0;
    endtask

    task automatic model_step(input logic r, input logic [NP-1:0] en_in, input logic rs,
                              input logic [NP-1:0] raw);
        logic [NP-1:0] lk;
        bit ok, lost;
        int k;
        lk = h2; h2 = h1; h1 = raw;
        if (r) begin
            m_st = S_IDLE; m_en = '0; m_retry = 0; m_loss = 0;
            m_prst = '1; m_drst = '1; h1 = '0; h2 = '0;
            return;
        end
        ok   = (lk & m_en) == m_en;
        lost = (m_st == S_REL || m_st == S_RUN) && !ok;
        if (lost && m_loss < (1 << CW) - 1) m_loss++;
        if (rs && m_st != S_IDLE) begin
            m_en = en_in; m_retry = 0; to_assert();
        end else if (m_st == S_IDLE) begin
            if (en_in != '0) begin m_en = en_in; to_assert(); end
        end else if (m_st == S_AST) begin
            m_el++;
            if (m_el == RP) begin m_st = S_WAIT; m_el = 0; m_run = 0; end
        end else if (m_st == S_WAIT) begin
            m_el++;
            m_run = ok ? m_run + 1 : 0;
            if (m_run == LS) begin
                m_st = S_REL; m_retry = 0; m_gap = 0; relq = {};
                for (int i = 0; i < NP; i++) if (m_en[i]) relq.push_back(i);
                m_drst = '1;
                if (relq.size() > 0) begin k = relq.pop_front(); m_drst[k] = 1'b0; end
            end else if (m_el == TO) begin
                m_retry++;
                if (m_retry == MR) m_st = S_FAIL; else to_assert();
            end
        end else if (lost) begin
            m_retry = 0; to_assert();
        end else if (m_st == S_REL) begin
            if (relq.size() == 0) m_st = S_RUN;
            else begin
                m_gap++;
                if (m_gap == RG) begin k = relq.pop_front(); m_drst[k] = 1'b0; m_gap = 0; end
            end
        end
        m_prst = (m_st == S_WAIT || m_st == S_REL || m_st == S_RUN) ? ~m_en : '1;
        if (m_st != S_REL && m_st != S_RUN) m_drst = '1;
    endtask

    task automatic tick();
        for (int i = 0; i < NP; i++)
            pll_locked_i[i] = !dead[i] && pcnt[i] >= dly[i] && !glitch[i]
                              && !(rand_mode && $urandom_range(0, 199) == 0);
        model_step(rst, enable_i, restart_i, pll_locked_i);
        @(posedge refclk);
        #1;
        for (int i = 0; i < NP; i++) pcnt[i] = m_prst[i] ? 0 : (pcnt[i] < 1000 ? pcnt[i] + 1 : pcnt[i]);
        glitch    = '0;
        restart_i = 1'b0;
        check("state", state_o, m_st);
        check("pll_rst", pll_rst_o, m_prst);
        check("domain_rst", domain_rst_o, m_drst);
        check("all_locked", all_locked_o, m_st == S_RUN);
        check("fail", fail_o, m_st == S_FAIL);
        check("retry", retry_count_o, m_retry);
        check("loss_cnt", lock_loss_count_o, m_loss);
    endtask

    task automatic wait_state(input int tgt, input int budget);
        int n = 0;
        while (state_o !== tgt && n < budget) begin tick(); n++; end
        if (state_o !== tgt) check("wait_state", state_o, tgt);
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; enable_i = '0; restart_i = 1'b0; glitch = '0; rand_mode = 1'b0;
        pll_locked_i = '0;
        for (int i = 0; i < NP; i++) begin dead[i] = 1'b0; dly[i] = 5; pcnt[i] = 0; end
        tick(); tick();
        check("rst_state", state_o, 0);
        check("rst_pll_rst", pll_rst_o, 2'b11);
        check("rst_dom_rst", domain_rst_o, 2'b11);
        rst = 1'b0;
        repeat (3) tick();
        check("idle_hold", state_o, 0);

        // nominal bring-up
        enable_i = 2'b11;
        wait_state(S_REL, 100);
        check("rel_entry_dom", domain_rst_o, 2'b10);
        tick();
        check("rel_gap_dom", domain_rst_o, 2'b10);
        tick();
        check("rel_second_dom", domain_rst_o, 2'b00);
        check("rel_not_run", all_locked_o, 0);
        tick();
        check("run_all_locked", all_locked_o, 1);
        check("run_retry", retry_count_o, 0);

        // single-cycle lock loss in RUN
        repeat (5) tick();
        glitch = 2'b01;
        tick();
        wait_state(S_AST, 10);
        check("loss_count", lock_loss_count_o, 1);
        check("loss_dom_rst", domain_rst_o, 2'b11);
        check("loss_all_locked", all_locked_o, 0);
        wait_state(S_RUN, 100);

        // timeout / FAIL / restart
        dead[1] = 1'b1;
        restart_i = 1'b1;
        tick();
        wait_state(S_FAIL, 200);
        check("fail_flag", fail_o, 1);
        check("fail_retry", retry_count_o, 3);
        check("fail_pll_rst", pll_rst_o, 2'b11);
        dead[1] = 1'b0;
        restart_i = 1'b1;
        tick();
        check("restart_state", state_o, 1);
        check("restart_fail", fail_o, 0);
        check("restart_retry", retry_count_o, 0);
        wait_state(S_RUN, 100);

        // mask: PLL0 disabled, its lock stays low
        enable_i = 2'b10;
        restart_i = 1'b1;
        tick();
        wait_state(S_RUN, 100);
        check("mask_run", all_locked_o, 1);
        check("mask_pll_rst0", pll_rst_o[0], 1);
        check("mask_dom_rst0", domain_rst_o[0], 1);

        // debounce glitch at stable count 6, then restart mid-RELEASE
        enable_i = 2'b11;
        restart_i = 1'b1;
        tick();
        begin
            int n = 0;
            while (!(m_st == S_WAIT && m_run == 6) && n < 100) begin tick(); n++; end
            if (n >= 100) check("dbc_reach", n, 0);
        end
        glitch = 2'b10;
        tick();
        wait_state(S_REL, 100);
        tick();
        restart_i = 1'b1;
        tick();
        check("rel_restart_state", state_o, 1);
        check("rel_restart_dom", domain_rst_o, 2'b11);

        // saturation of the lock-loss counter
        for (int k = 0; k < 5; k++) begin
            wait_state(S_RUN, 100);
            glitch = 2'b01;
            tick();
            wait_state(S_AST, 10);
        end
        check("loss_saturated", lock_loss_count_o, 3);

        // randomized episodes
        rand_mode = 1'b1;
        for (int e = 0; e < 40; e++) begin
            enable_i = 2'($urandom_range(1, 3));
            for (int i = 0; i < NP; i++) begin
                dly[i]  = $urandom_range(1, 14);
                dead[i] = $urandom_range(0, 15) == 0;
            end
            restart_i = 1'b1;
            repeat ($urandom_range(20, 150)) begin
                tick();
                restart_i = $urandom_range(0, 99) == 0;
            end
        end
        rand_mode = 1'b0;

        // reset mid-WAIT_LOCK
        for (int i = 0; i < NP; i++) begin dead[i] = 1'b0; dly[i] = 5; end
        enable_i = 2'b11;
        restart_i = 1'b1;
        tick();
        wait_state(S_WAIT, 50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_state", state_o, 0);
        check("mid_rst_pll_rst", pll_rst_o, 2'b11);
        check("mid_rst_dom_rst", domain_rst_o, 2'b11);
        check("mid_rst_all_locked", all_locked_o, 0);
        check("mid_rst_fail", fail_o, 0);
        check("mid_rst_retry", retry_count_o, 0);
        check("mid_rst_loss", lock_loss_count_o, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Parametrised reset and lock supervisor for up to NUM_PLL PLL instances, such as the two-output 10 MHz/125 MHz generator. It runs on the 10 MHz reference clock and drives each PLL's rst. It waits for a debounced lock with a timeout and retries, then releases the downstream domain resets in a staggered order. On lock loss it re-sequences automatically and counts the event, which the single-PLL instantiation cannot do.

Parameters:
NUM_PLL, 2, number of supervised PLLs (1..8)
RST_PULSE_CYCLES, 16, refclk cycles PLL rst is held asserted per attempt (>=1)
LOCK_STABLE_CYCLES, 1000, consecutive cycles all enabled locks must be high (>=1)
LOCK_TIMEOUT_CYCLES, 100000, cycles in WAIT_LOCK before an attempt is declared failed
MAX_RETRIES, 3, failed attempts before entering FAIL (>=1)
RELEASE_GAP, 4, cycles between successive domain reset releases (>=1)
CNT_W, 8, width of lock_loss_count_o

Ports:
refclk  in  1  single clock, 10 MHz reference
rst  in  1  synchronous, active-high reset
enable_i  in  NUM_PLL  per-PLL enable mask; latched on IDLE exit and on restart
restart_i  in  1  single-cycle request to re-sequence from ASSERT_RST
pll_locked_i  in  NUM_PLL  raw PLL locked signals, asynchronous, synchronised internally
pll_rst_o  out  NUM_PLL  per-PLL reset
domain_rst_o  out  NUM_PLL  per-PLL downstream domain reset, active-high
all_locked_o  out  1  high only in RUN
fail_o  out  1  high only in FAIL
retry_count_o  out  $clog2(MAX_RETRIES+1)  failed attempts in the current sequence
lock_loss_count_o  out  CNT_W  saturating count of lock-loss events since rst
state_o  out  3  current state encoding, for status registers

Behaviour:
- Reset values (in effect the cycle after rst is sampled high): state IDLE; pll_rst_o all 1; domain_rst_o all 1; all_locked_o 0; fail_o 0; both counters 0. Reset mid-sequence aborts immediately with the same values.
- Lock sync: 2-flop synchroniser per bit, so there are 2 cycles of latency; all decisions use the synced value lk.
- Mask "en" is latched as described under enable_i. Disabled PLLs always have pll_rst_o=1 and domain_rst_o=1, and their lk is ignored.
- IDLE: stay while enable_i==0. Otherwise latch en and go to ASSERT_RST.
- ASSERT_RST: pll_rst_o=1 for all bits; domain_rst_o all 1. After exactly RST_PULSE_CYCLES cycles go to WAIT_LOCK. On WAIT_LOCK entry, pll_rst_o[i]=~en[i].
- WAIT_LOCK: timeout timer increments every cycle. A stable counter increments while (lk & en)==en and clears to 0 otherwise.
  - Stable counter reaches LOCK_STABLE_CYCLES: go to RELEASE and clear retry_count.
  - Timer reaches LOCK_TIMEOUT_CYCLES first: retry_count+1. If the new value equals MAX_RETRIES go to FAIL, else go to ASSERT_RST.
  - If the stable and timeout conditions occur in the same cycle, stable wins.
- RELEASE: deassert domain_rst_o of enabled PLLs one at a time in ascending index order, RELEASE_GAP cycles apart. The first deassertion happens on RELEASE entry; disabled indices are skipped without consuming a gap. After the last enabled index is released, go to RUN on the next cycle.
- RUN: all_locked_o=1. If any enabled lk is 0 for one cycle:
  - lock_loss_count_o+1 (saturating at all-ones);
  - next cycle: domain_rst_o all 1, all_locked_o 0, retry_count 0, state ASSERT_RST.
- A lock drop during RELEASE is handled the same way as in RUN: counted and re-sequenced.
- FAIL: pll_rst_o all 1, domain_rst_o all 1, fail_o=1. Exit only via restart_i or rst.
- restart_i in any state except IDLE:
  - next state ASSERT_RST; relatch en; retry_count 0; fail_o 0; domain resets asserted.
  - Restart wins over every other transition. A simultaneous lock loss in RUN is still counted.
- restart_i in IDLE is ignored; IDLE is governed by enable_i.
- All outputs are registered.
- Encoding: IDLE 0, ASSERT_RST 1, WAIT_LOCK 2, RELEASE 3, RUN 4, FAIL 5.
- Timers are sized from $clog2 of their limit parameters.

Decomposition:
- Package pll_seq_pkg: state enum with the encodings above; the state_o width constant (3); a width helper function for timer sizing.
- One sub-module, pll_lock_sync: NUM_PLL-wide 2-flop synchroniser with a synchronous reset to 0.
- The FSM, timers and release scheduler stay in pll_reset_sequencer.

Test Plan:
Use NUM_PLL=2, RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=3, RELEASE_GAP=2.
- Nominal: enable_i=2'b11; both locks rise 5 cycles after pll_rst_o falls.
  -> pll_rst_o high for exactly 4 cycles.
  -> RELEASE entered 2+8 cycles after the locks rise.
  -> domain_rst_o[0] falls, then domain_rst_o[1] 2 cycles later.
  -> all_locked_o=1 the cycle after that; retry_count_o=0.
- Timeout/fail: lock[1] never rises.
  -> three ASSERT_RST pulses, 4+32 cycles apart.
  -> retry_count_o steps 1, 2, 3; then state 5, fail_o=1, pll_rst_o=2'b11.
  -> then restart_i -> state 1, fail_o=0, retry_count_o=0.
- Lock loss in RUN: drop lock[0] for 1 cycle.
  -> lock_loss_count_o 0->1.
  -> domain_rst_o=2'b11 and all_locked_o=0 the following cycle.
  -> full re-sequence back to RUN.
- Mask: enable_i=2'b10.
  -> pll_rst_o[0] and domain_rst_o[0] stay 1 throughout; lock[0] held low does not block RUN.
  -> domain_rst_o[1] is released on RELEASE entry.
- Debounce: lock[1] glitches low at stable count 6.
  -> stable counter restarts; RELEASE delayed by 8 more cycles.
  -> with restart_i pulsed mid-RELEASE: state 1 next cycle, domain_rst_o=2'b11.
- Saturation and reset: CNT_W=2, 5 lock losses -> lock_loss_count_o=3. Then rst mid-WAIT_LOCK -> all reset values the next cycle, counter 0.
